spi_flash_arbiter: RTL and testbench
====================================

# spi_flash_arbiter

Shares the single board SPI flash between two SPI masters: requester 0 is the USB-to-SPI bridge endpoint, requester 1 is a local on-chip flash reader (e.g. warm-boot/config fetch). Grants whole transactions round-robin, muxes the granted master's pins onto the flash, and holds the flash deselected for a guard interval between owners. Sits between the masters and the top-level SPI pads.

## Interface
- `GUARD_CYCLES`, default 2: minimum cycles flash CS_b is forced high between owners; legal range 1..255.
- `RELEASE_TIMEOUT`, default 16: cycles the owner may hold CS_b low after dropping its request; legal range 1..255.
- `clk` in 1: sole clock.
- `reset_n` in 1: synchronous, active-low reset.
- `m0_req` / `m1_req` in 1: requester wants the flash; held high for the whole transaction.
- `m0_gnt` / `m1_gnt` out 1: requester owns the flash.
- `m0_cs_b`, `m0_sck`, `m0_mosi` / `m1_cs_b`, `m1_sck`, `m1_mosi` in 1 each: requester SPI outputs.
- `m0_miso` / `m1_miso` out 1 each: flash MISO, gated by ownership.
- `spi_cs_b`, `spi_sck`, `spi_mosi` out 1 each: flash pins.
- `spi_miso` in 1: flash data out.
- `busy` out 1: state is not ARB_IDLE.
- `timeout_err` out 1: sticky; set on release timeout; cleared only by reset.

## Operation
- State machine, registered state, owner index and round-robin pointer:
  - ARB_IDLE: flash forced idle. If any request is pending, pick the owner, set the grant, go to ARB_OWN.
  - ARB_OWN: flash pins follow the owner's pins. When the owner's req is low: clear the grant. If the owner's cs_b is 1, go to ARB_GUARD; otherwise go to ARB_RELEASE.
  - ARB_RELEASE: flash pins still follow the owner; the counter increments each cycle. When the owner's cs_b is 1, go to ARB_GUARD. When the counter reaches RELEASE_TIMEOUT, set timeout_err and go to ARB_GUARD.
  - ARB_GUARD: flash forced idle; counter counts GUARD_CYCLES, then go to ARB_IDLE.
- Forced idle means spi_cs_b=1, spi_sck=1, spi_mosi=0.
- Owner selection when only one request is pending: that requester.
- Owner selection when both are pending: the requester named by the pointer (reset 0).
- The pointer is set to the non-owner on every grant.
- Re-raising req during ARB_RELEASE or ARB_GUARD has no effect until ARB_IDLE.
- MISO gating: the owner's miso equals spi_miso in ARB_OWN and ARB_RELEASE. Every other miso is 0.
- Both gnt outputs are never high together.
- Counter: 8 bits, cleared on each state entry.
- Pin mux is combinational on registered owner/state, so SPI bit timing is unchanged.

## Timing
- Reset values:
  - gnt=0 for both requesters.
  - spi_cs_b=1, spi_sck=1, spi_mosi=0.
  - miso=0 for both requesters.
  - busy=0, timeout_err=0, pointer=0, state ARB_IDLE.
- Grant latency: req sampled high in ARB_IDLE at edge N gives gnt high and the mux switched from N+1.
- Release: req sampled low at edge M with cs_b=1 gives gnt low at M+1 and forced idle from M+1.
- Gap between owners: spi_cs_b stays high for at least GUARD_CYCLES + 1 cycles (guard plus one idle cycle).
- Back-to-back re-grant is possible at the earliest GUARD_CYCLES + 1 cycles after leaving ARB_OWN/ARB_RELEASE.
- Timeout: after entering ARB_RELEASE with cs_b held low, forced idle begins on the cycle after the counter equals RELEASE_TIMEOUT. timeout_err rises on that same edge.
- Reset mid-transaction: the next edge with reset_n=0 forces all outputs to reset values; spi_cs_b is high one edge later.
- req glitch during ARB_OWN: any single cycle of req=0 is treated as release.

## Structure
- Package `spi_arb_pkg` holds:
  - the state enum (ARB_IDLE, ARB_OWN, ARB_RELEASE, ARB_GUARD);
  - requester index constants REQ_USB=0 and REQ_LOCAL=1;
  - the forced-idle pin values.
- One sub-module, `spi_arb_pin_mux`: combinational selection of the flash pins and MISO gating from owner index and state.
- The FSM, counter and pointer live in the top module.

## Test plan
- Single requester: m0_req rises at cycle 10 → m0_gnt at 11. Toggle m0_sck/m0_mosi; spi_sck/spi_mosi mirror them the same cycle. m1_miso stays 0.
- Contention: both req rise at cycle 5 → m0 granted first. m0 drops req with cs_b=1 at cycle 40 → m1_gnt at 40+1+2+1=44. spi_cs_b is high for cycles 41–43.
- Round-robin: three back-to-back transactions with both requesters always pending → grant order m0, m1, m0.
- Late release: m0 drops req while m0_cs_b=0 and raises cs_b 5 cycles later → spi_cs_b follows m0 throughout, no timeout_err. Guard follows.
- Timeout: m0 drops req and never raises cs_b (RELEASE_TIMEOUT=16) → spi_cs_b forced high 17 cycles after ARB_RELEASE entry. timeout_err=1 and stays set until reset.
- Reset mid-transfer: reset_n low during ARB_OWN with spi_cs_b=0 → next edge: all outputs at reset values, busy=0.

Source files
------------

// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the two-master SPI flash arbiter.
// Covers the FSM states, requester indices and flash idle pin levels.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_OWN     = 2'd1,
    ARB_RELEASE = 2'd2,
    ARB_GUARD   = 2'd3
  } arb_state_t;

  localparam logic REQ_USB   = 1'b0;
  localparam logic REQ_LOCAL = 1'b1;

  localparam logic IDLE_CS_B = 1'b1;
  localparam logic IDLE_SCK  = 1'b1;
  localparam logic IDLE_MOSI = 1'b0;

endpackage

// File: rtl/spi_arb_pin_mux.sv
// Flash pin selection and MISO gating from the registered owner and state.
// Purely combinational, so the owner's SPI bit timing reaches the pads untouched.
module spi_arb_pin_mux
  import spi_arb_pkg::*;
(
  input  arb_state_t i_state,
  input  logic       i_owner,
  input  logic       i_m0_cs_b,
  input  logic       i_m0_sck,
  input  logic       i_m0_mosi,
  input  logic       i_m1_cs_b,
  input  logic       i_m1_sck,
  input  logic       i_m1_mosi,
  input  logic       i_spi_miso,
  output logic       o_spi_cs_b,
  output logic       o_spi_sck,
  output logic       o_spi_mosi,
  output logic       o_m0_miso,
  output logic       o_m1_miso
);

  logic w_pass;

  assign w_pass = (i_state == ARB_OWN) ||
                  (i_state == ARB_RELEASE);

  always_comb begin
    o_spi_cs_b = IDLE_CS_B;
    o_spi_sck  = IDLE_SCK;
    o_spi_mosi = IDLE_MOSI;
    o_m0_miso  = 1'b0;
    o_m1_miso  = 1'b0;
    if (w_pass) begin
      unique case (i_owner)
        REQ_USB: begin
          o_spi_cs_b = i_m0_cs_b;
          o_spi_sck  = i_m0_sck;
          o_spi_mosi = i_m0_mosi;
          o_m0_miso  = i_spi_miso;
        end
        REQ_LOCAL: begin
          o_spi_cs_b = i_m1_cs_b;
          o_spi_sck  = i_m1_sck;
          o_spi_mosi = i_m1_mosi;
          o_m1_miso  = i_spi_miso;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/spi_flash_arbiter.sv
// Round-robin owner of the board SPI flash for the USB bridge and local reader.
// Grants whole transactions and keeps the flash deselected between owners.
module spi_flash_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned GUARD_CYCLES    = 2,
  parameter int unsigned RELEASE_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic m0_req,
  input  logic m1_req,
  output logic m0_gnt,
  output logic m1_gnt,
  input  logic m0_cs_b,
  input  logic m0_sck,
  input  logic m0_mosi,
  input  logic m1_cs_b,
  input  logic m1_sck,
  input  logic m1_mosi,
  output logic m0_miso,
  output logic m1_miso,
  output logic spi_cs_b,
  output logic spi_sck,
  output logic spi_mosi,
  input  logic spi_miso,
  output logic busy,
  output logic timeout_err
);

  localparam logic [7:0] GUARD_LAST = 8'(GUARD_CYCLES - 1);
  localparam logic [7:0] TO_LAST    = 8'(RELEASE_TIMEOUT);

  arb_state_t r_state, w_state_nxt;
  logic       r_owner, w_owner_nxt;
  logic       r_ptr,   w_ptr_nxt;
  logic [1:0] r_gnt,   w_gnt_nxt;
  logic [7:0] r_cnt,   w_cnt_nxt;
  logic       r_terr,  w_terr_nxt;
  logic       w_own_req;
  logic       w_own_cs_b;

  assign w_own_req  = r_owner ? m1_req  : m0_req;
  assign w_own_cs_b = r_owner ? m1_cs_b : m0_cs_b;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ARB_IDLE;
      r_owner <= REQ_USB;
      r_ptr   <= REQ_USB;
      r_gnt   <= 2'b00;
      r_cnt   <= 8'd0;
      r_terr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
      r_gnt   <= w_gnt_nxt;
      r_cnt   <= w_cnt_nxt;
      r_terr  <= w_terr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_gnt_nxt   = r_gnt;
    w_cnt_nxt   = r_cnt;
    w_terr_nxt  = r_terr;
    unique case (r_state)
      ARB_IDLE: begin
        if (m0_req || m1_req) begin
          // With a single request m1_req alone names the owner.
          w_owner_nxt = (m0_req && m1_req) ? r_ptr : m1_req;
          w_ptr_nxt   = ~w_owner_nxt;
          w_gnt_nxt   = w_owner_nxt ? 2'b10 : 2'b01;
          w_state_nxt = ARB_OWN;
          w_cnt_nxt   = 8'd0;
        end
      end
      ARB_OWN: begin
        if (!w_own_req) begin
          w_gnt_nxt   = 2'b00;
          w_cnt_nxt   = 8'd0;
          w_state_nxt = w_own_cs_b ? ARB_GUARD
                                   : ARB_RELEASE;
        end
      end
      ARB_RELEASE: begin
        if (w_own_cs_b) begin
          w_state_nxt = ARB_GUARD;
          w_cnt_nxt   = 8'd0;
        end else if (r_cnt == TO_LAST) begin
          w_terr_nxt  = 1'b1;
          w_state_nxt = ARB_GUARD;
          w_cnt_nxt   = 8'd0;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      ARB_GUARD: begin
        if (r_cnt == GUARD_LAST) begin
          w_state_nxt = ARB_IDLE;
          w_cnt_nxt   = 8'd0;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  assign m0_gnt      = r_gnt[0];
  assign m1_gnt      = r_gnt[1];
  assign busy        = (r_state != ARB_IDLE);
  assign timeout_err = r_terr;

  spi_arb_pin_mux u_mux (
    .i_state    (r_state),
    .i_owner    (r_owner),
    .i_m0_cs_b  (m0_cs_b),
    .i_m0_sck   (m0_sck),
    .i_m0_mosi  (m0_mosi),
    .i_m1_cs_b  (m1_cs_b),
    .i_m1_sck   (m1_sck),
    .i_m1_mosi  (m1_mosi),
    .i_spi_miso (spi_miso),
    .o_spi_cs_b (spi_cs_b),
    .o_spi_sck  (spi_sck),
    .o_spi_mosi (spi_mosi),
    .o_m0_miso  (m0_miso),
    .o_m1_miso  (m1_miso)
  );

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Scenario bench for spi_flash_arbiter with randomized pin traffic.
// Expected timing comes from grant/guard/timeout cycle arithmetic.
module tb_spi_flash_arbiter;

  localparam int G  = 2;
  localparam int TO = 16;
  localparam logic [8:0] RST_OUTS = 9'b001100000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic m0_req = 1'b0, m1_req = 1'b0;
  logic m0_cs_b = 1'b1, m0_sck = 1'b1, m0_mosi = 1'b0;
  logic m1_cs_b = 1'b1, m1_sck = 1'b1, m1_mosi = 1'b0;
  logic spi_miso = 1'b0;
  logic m0_gnt, m1_gnt, m0_miso, m1_miso;
  logic spi_cs_b, spi_sck, spi_mosi, busy, timeout_err;
  logic [8:0] outs;

  int n_chk = 0;
  int n_fail = 0;

  assign outs = {m0_gnt, m1_gnt, spi_cs_b, spi_sck, spi_mosi,
                 m0_miso, m1_miso, busy, timeout_err};

  always #5 clk = ~clk;

  spi_flash_arbiter #(
    .GUARD_CYCLES    (G),
    .RELEASE_TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .m0_req      (m0_req),
    .m1_req      (m1_req),
    .m0_gnt      (m0_gnt),
    .m1_gnt      (m1_gnt),
    .m0_cs_b     (m0_cs_b),
    .m0_sck      (m0_sck),
    .m0_mosi     (m0_mosi),
    .m1_cs_b     (m1_cs_b),
    .m1_sck      (m1_sck),
    .m1_mosi     (m1_mosi),
    .m0_miso     (m0_miso),
    .m1_miso     (m1_miso),
    .spi_cs_b    (spi_cs_b),
    .spi_sck     (spi_sck),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    m0_req = 1'b0; m1_req = 1'b0;
    m0_cs_b = 1'b1; m0_sck = 1'b1; m0_mosi = 1'b0;
    m1_cs_b = 1'b1; m1_sck = 1'b1; m1_mosi = 1'b0;
    spi_miso = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    m0_req = 1'b1; m1_req = 1'b1;
    m0_cs_b = 1'b0; m0_sck = 1'b0; m0_mosi = 1'b1;
    spi_miso = 1'b1;
    step();
    step();
    n_chk++; if (outs !== RST_OUTS) begin n_fail++; $display("FAIL reset_outs got %b exp %b", outs, RST_OUTS); end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    step();
    m0_req = 1'b1;
    #1;
    n_chk++; if (m0_gnt !== 1'b0) begin n_fail++; $display("FAIL single_pre_gnt got %b exp 0", m0_gnt); end
    step();
    n_chk++; if ({m0_gnt, m1_gnt, busy} !== 3'b101) begin n_fail++; $display("FAIL single_gnt got %b exp 101", {m0_gnt, m1_gnt, busy}); end
    m0_cs_b = 1'b0;
    for (int i = 0; i < 8; i++) begin
      m0_sck = 1'($urandom); m0_mosi = 1'($urandom);
      m1_sck = 1'($urandom); m1_mosi = 1'($urandom);
      m1_cs_b = 1'($urandom); spi_miso = 1'($urandom);
      #1;
      n_chk++; if ({spi_cs_b, spi_sck, spi_mosi, m0_miso, m1_miso} !== {1'b0, m0_sck, m0_mosi, spi_miso, 1'b0}) begin n_fail++; $display("FAIL single_mux got %b exp %b", {spi_cs_b, spi_sck, spi_mosi, m0_miso, m1_miso}, {1'b0, m0_sck, m0_mosi, spi_miso, 1'b0}); end
      step();
    end
    m1_cs_b = 1'b1;
    m0_cs_b = 1'b1; m0_req = 1'b0; m0_sck = 1'b0; m0_mosi = 1'b1;
    step();
    n_chk++; if ({m0_gnt, spi_cs_b, spi_sck, spi_mosi, busy} !== 5'b01101) begin n_fail++; $display("FAIL single_release got %b exp 01101", {m0_gnt, spi_cs_b, spi_sck, spi_mosi, busy}); end
    for (int i = 1; i <= G; i++) begin
      step();
      n_chk++; if (busy !== (i < G)) begin n_fail++; $display("FAIL single_guard_busy got %b exp %b at %0d", busy, (i < G), i); end
    end
  endtask

  task automatic test_contention();
    int n;
    do_reset();
    m0_req = 1'b1; m1_req = 1'b1;
    step();
    n_chk++; if ({m0_gnt, m1_gnt} !== 2'b10) begin n_fail++; $display("FAIL cont_first got %b exp 10", {m0_gnt, m1_gnt}); end
    m0_cs_b = 1'b0;
    n = $urandom_range(3, 10);
    for (int i = 0; i < n; i++) begin
      m0_sck = 1'($urandom); m1_sck = 1'($urandom);
      m1_cs_b = 1'($urandom);
      #1;
      n_chk++; if ({m0_gnt, m1_gnt, spi_cs_b, spi_sck} !== {2'b10, 1'b0, m0_sck}) begin n_fail++; $display("FAIL cont_hold got %b exp %b", {m0_gnt, m1_gnt, spi_cs_b, spi_sck}, {2'b10, 1'b0, m0_sck}); end
      step();
    end
    m0_cs_b = 1'b1; m1_cs_b = 1'b1; m0_req = 1'b0;
    step();
    for (int i = 0; i <= G; i++) begin
      n_chk++; if ({m1_gnt, spi_cs_b} !== 2'b01) begin n_fail++; $display("FAIL cont_gap got %b exp 01 at %0d", {m1_gnt, spi_cs_b}, i); end
      step();
    end
    n_chk++; if ({m0_gnt, m1_gnt} !== 2'b01) begin n_fail++; $display("FAIL cont_second got %b exp 01", {m0_gnt, m1_gnt}); end
  endtask

  task automatic test_round_robin();
    logic exp_owner;
    int w, len, exp_lat;
    do_reset();
    exp_owner = 1'b0;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int t = 0; t < 6; t++) begin
      w = 0;
      exp_lat = (t == 0) ? 1 : G + 1;
      while (!(m0_gnt || m1_gnt) && w < 20) begin step(); w++; end
      n_chk++; if (w !== exp_lat) begin n_fail++; $display("FAIL rr_latency got %0d exp %0d txn %0d", w, exp_lat, t); end
      n_chk++; if ({m1_gnt, m0_gnt} !== (exp_owner ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL rr_owner got %b exp owner %0d txn %0d", {m1_gnt, m0_gnt}, exp_owner, t); end
      len = $urandom_range(1, 5);
      for (int i = 0; i < len; i++) begin
        m0_sck = 1'($urandom); m1_sck = 1'($urandom);
        #1;
        n_chk++; if ({m0_gnt && m1_gnt, spi_sck} !== {1'b0, (exp_owner ? m1_sck : m0_sck)}) begin n_fail++; $display("FAIL rr_mux got %b exp %b txn %0d", {m0_gnt && m1_gnt, spi_sck}, {1'b0, (exp_owner ? m1_sck : m0_sck)}, t); end
        step();
      end
      if (exp_owner) m1_req = 1'b0;
      else m0_req = 1'b0;
      step();
      m0_req = 1'b1; m1_req = 1'b1;
      exp_owner = ~exp_owner;
    end
  endtask

  task automatic test_late_release();
    int d;
    do_reset();
    m0_req = 1'b1;
    step();
    m0_cs_b = 1'b0;
    step();
    step();
    d = $urandom_range(1, TO - 1);
    m0_req = 1'b0;
    step();
    n_chk++; if ({m0_gnt, spi_cs_b, busy} !== 3'b001) begin n_fail++; $display("FAIL late_enter got %b exp 001", {m0_gnt, spi_cs_b, busy}); end
    for (int i = 0; i < d; i++) begin
      m0_sck = 1'($urandom); m0_mosi = 1'($urandom);
      spi_miso = 1'($urandom);
      #1;
      n_chk++; if ({spi_cs_b, spi_sck, spi_mosi, m0_miso} !== {1'b0, m0_sck, m0_mosi, spi_miso}) begin n_fail++; $display("FAIL late_follow got %b exp %b at %0d", {spi_cs_b, spi_sck, spi_mosi, m0_miso}, {1'b0, m0_sck, m0_mosi, spi_miso}, i); end
      step();
    end
    m0_cs_b = 1'b1; m0_sck = 1'b0; m0_mosi = 1'b1;
    #1;
    n_chk++; if ({spi_cs_b, spi_sck, busy} !== 3'b101) begin n_fail++; $display("FAIL late_csb_up got %b exp 101", {spi_cs_b, spi_sck, busy}); end
    step();
    n_chk++; if ({spi_cs_b, spi_sck, spi_mosi, m0_miso, timeout_err} !== 5'b11000) begin n_fail++; $display("FAIL late_guard got %b exp 11000", {spi_cs_b, spi_sck, spi_mosi, m0_miso, timeout_err}); end
    repeat (G) step();
    n_chk++; if ({busy, timeout_err} !== 2'b00) begin n_fail++; $display("FAIL late_idle got %b exp 00", {busy, timeout_err}); end
  endtask

  task automatic test_timeout();
    do_reset();
    m0_req = 1'b1;
    step();
    m0_cs_b = 1'b0;
    step();
    m0_req = 1'b0;
    step();
    for (int k = 1; k <= TO; k++) begin
      step();
      n_chk++; if ({spi_cs_b, timeout_err} !== 2'b00) begin n_fail++; $display("FAIL to_wait got %b exp 00 at %0d", {spi_cs_b, timeout_err}, k); end
    end
    step();
    n_chk++; if ({spi_cs_b, timeout_err, m0_gnt} !== 3'b110) begin n_fail++; $display("FAIL to_fire got %b exp 110", {spi_cs_b, timeout_err, m0_gnt}); end
    repeat (G) step();
    m0_cs_b = 1'b1; m0_req = 1'b1;
    step();
    step();
    m0_req = 1'b0;
    step();
    repeat (G + 2) step();
    n_chk++; if ({timeout_err, busy} !== 2'b10) begin n_fail++; $display("FAIL to_sticky got %b exp 10", {timeout_err, busy}); end
    do_reset();
    n_chk++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_clear got %b exp 0", timeout_err); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    m0_req = 1'b1;
    step();
    m0_cs_b = 1'b0; m0_sck = 1'b0; m0_mosi = 1'b1;
    step();
    n_chk++; if ({m0_gnt, spi_cs_b} !== 2'b10) begin n_fail++; $display("FAIL mid_owning got %b exp 10", {m0_gnt, spi_cs_b}); end
    m1_req = 1'b1;
    spi_miso = 1'b1;
    reset_n = 1'b0;
    step();
    n_chk++; if (outs !== RST_OUTS) begin n_fail++; $display("FAIL mid_outs got %b exp %b", outs, RST_OUTS); end
    reset_n = 1'b1;
    step();
    n_chk++; if ({m0_gnt, m1_gnt} !== 2'b10) begin n_fail++; $display("FAIL mid_ptr got %b exp 10", {m0_gnt, m1_gnt}); end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_round_robin();
    test_late_release();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
